adaptive_threshold_engine: RTL and testbench
============================================

# adaptive_threshold_engine

Parametrised successor to the single-mode thresholding block. It scans a 2^WIDTH_BITS × 2^HEIGHT_BITS image in raster order and reads each pixel and its local threshold from two synchronous memories. For each pixel it applies one of four selectable threshold modes, with a signed threshold offset and programmable high/low output levels. It writes the result to a result memory and reports the count of pixels classified high. The block sits between the box-filter/threshold-map stage and the result RAM, and is started and monitored by the frame controller.

## Interface
- WIDTH_BITS, 8, column address width; image width = 2^WIDTH_BITS
- HEIGHT_BITS, 8, row address width; image height = 2^HEIGHT_BITS
- DATA_BITS, 8, pixel/threshold/result width
- OFFSET_BITS, 8, width of signed offset
- MEM_LATENCY, 1, read latency of both source memories in cycles; legal range 1..4
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- iStart  in  1  start pulse; sampled only in IDLE or DONE
- iMode  in  2  0 binary, 1 inverse binary, 2 truncate, 3 to-zero
- iOffset  in  OFFSET_BITS  signed offset C subtracted from threshold
- iHigh, iLow  in  DATA_BITS each  output levels for modes 0/1
- oImageCol / oImageRow  out  WIDTH_BITS / HEIGHT_BITS  image memory address
- iImageData  in  DATA_BITS  pixel, valid MEM_LATENCY cycles after address
- oThresholdCol / oThresholdRow  out  WIDTH_BITS / HEIGHT_BITS  threshold memory address, always equal to image address
- iThresholdData  in  DATA_BITS  threshold, same latency as image
- oResultCol / oResultRow  out  WIDTH_BITS / HEIGHT_BITS  result write address
- oResultData  out  DATA_BITS  result pixel
- oResultWren  out  1  result write strobe, one cycle per pixel
- oBusy  out  1  high in RUN and DRAIN
- finished  out  1  high in DONE
- oCountHigh  out  WIDTH_BITS+HEIGHT_BITS+1  pixels with pixel > t' in last/current frame

## Operation
- States:
  - IDLE → RUN on iStart.
  - RUN issues one address per cycle; → DRAIN after address (W-1,H-1).
  - DRAIN → DONE after the last write.
  - DONE → RUN on iStart; otherwise DONE holds.
- iStart in RUN/DRAIN is ignored.
- On start accept: iMode, iOffset, iHigh, iLow are latched; oCountHigh cleared; address counters set to (0,0).
- Raster order: column increments fastest; column wraps W-1→0 with row+1; row wrap ends the scan.
- Effective threshold t' = thr − sign-extended offset, computed in max(DATA_BITS,OFFSET_BITS)+2 bits, saturated to [0, 2^DATA_BITS−1].
- Comparison is strict: hi = (pixel > t'), unsigned.
- Result by mode:
  - 0: hi ? iHigh : iLow
  - 1: hi ? iLow : iHigh
  - 2: hi ? t' : pixel
  - 3: hi ? pixel : 0
- oCountHigh increments on each write with hi=1. Its width holds W*H, so no saturation.
- Write address is the issue address delayed by MEM_LATENCY+1 cycles through a shift register.

## Timing
- Reset values (reset=0 at an edge): state IDLE; all address outputs 0, oResultData 0, oResultWren 0, oBusy 0, finished 0, oCountHigh 0. Latched config is cleared to 0.
- Let cycle 0 be the edge at which iStart is sampled; N = 2^(WIDTH_BITS+HEIGHT_BITS).
- Address for pixel n is registered and visible after edge 1+n; oBusy is high from edge 1.
- Compare/select is registered. oResultWren for pixel n is high for exactly one cycle after edge 2+n+MEM_LATENCY.
- Writes are contiguous: N back-to-back cycles, with no gaps.
- finished rises after edge N+MEM_LATENCY+2 and oBusy falls on the same edge. finished holds until iStart or reset.
- oCountHigh is final when finished rises and holds in DONE.
- Restart from DONE: finished drops and the new scan begins with identical timing.
- Reset mid-frame: the next edge with reset=0 aborts the scan. No further oResultWren occurs from that edge onward, including in-flight pipeline entries.
- Address outputs hold their last value in DRAIN/DONE. oResultData holds its last value when oResultWren=0.

## Test plan
- WIDTH_BITS=HEIGHT_BITS=2, MEM_LATENCY=1, mode 0, offset 0, high 255/low 0; pixel=16n, thr=128 constant → 16 writes in raster order. Pixels 0–8 (0..128) get 0; pixels 9–15 get 255; oCountHigh=7; finished rises 19 cycles after start.
- Same image, offset=+16 (t'=112) then −16 (t'=144) → oCountHigh 8 then 6; mode 1 gives the bitwise-swapped levels.
- Saturation: thr=5, offset=+20 → t'=0 and every nonzero pixel is high. thr=250, offset=−20 → t'=255, oCountHigh=0.
- Modes 2/3 with pixel=200, thr=100: mode 2 writes 100, mode 3 writes 200. With pixel=50, mode 2 writes 50 and mode 3 writes 0.
- MEM_LATENCY=3 with a matching-latency memory model: each write address equals its pixel's coordinates; wren is contiguous for 16 cycles; finished rises 21 cycles after start.
- Assert reset low at write 5 → no wren afterwards; all outputs at reset values. iStart during RUN is ignored; restart after DONE repeats the identical result sequence.

Source files
------------

// File: rtl/adaptive_threshold_engine_if.sv
// Memory-side bus of the adaptive threshold engine: image/threshold reads and result writes.
// Signal names keep the original port names so existing memory wrappers map one-to-one.
interface adaptive_threshold_engine_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int DATA_BITS   = 8
);
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  logic [DATA_BITS-1:0]   iImageData;
  logic [WIDTH_BITS-1:0]  oThresholdCol;
  logic [HEIGHT_BITS-1:0] oThresholdRow;
  logic [DATA_BITS-1:0]   iThresholdData;
  logic [WIDTH_BITS-1:0]  oResultCol;
  logic [HEIGHT_BITS-1:0] oResultRow;
  logic [DATA_BITS-1:0]   oResultData;
  logic                   oResultWren;

  modport master (
    output oImageCol, oImageRow, oThresholdCol, oThresholdRow,
    input  iImageData, iThresholdData,
    output oResultCol, oResultRow, oResultData, oResultWren
  );

  modport slave (
    input  oImageCol, oImageRow, oThresholdCol, oThresholdRow,
    output iImageData, iThresholdData,
    input  oResultCol, oResultRow, oResultData, oResultWren
  );
endinterface

// File: rtl/adaptive_threshold_engine.sv
// Raster-scan adaptive thresholding: reads pixel and local threshold, applies one of four
// modes with a signed offset, writes the result and counts pixels classified high.
module adaptive_threshold_engine #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int DATA_BITS   = 8,
  parameter int OFFSET_BITS = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                iStart,
  input  logic [1:0]                          iMode,
  input  logic signed [OFFSET_BITS-1:0]       iOffset,
  input  logic [DATA_BITS-1:0]                iHigh,
  input  logic [DATA_BITS-1:0]                iLow,
  adaptive_threshold_engine_if.master         memBus,
  output logic                                oBusy,
  output logic                                finished,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]     oCountHigh
);

  localparam int EXT_BITS = ((DATA_BITS > OFFSET_BITS) ? DATA_BITS : OFFSET_BITS) + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {MODE_BINARY, MODE_INVERSE, MODE_TRUNCATE, MODE_TOZERO} mode_t;

  typedef struct packed {
    logic                   valid;
    logic [WIDTH_BITS-1:0]  col;
    logic [HEIGHT_BITS-1:0] row;
  } tag_t;

  state_t state, nextState;

  mode_t                          modeReg;
  logic signed [OFFSET_BITS-1:0]  offsetReg;
  logic [DATA_BITS-1:0]           highReg, lowReg;

  logic [WIDTH_BITS-1:0]  colCount;
  logic [HEIGHT_BITS-1:0] rowCount;
  logic                   issueValid;
  tag_t                   pipe [MEM_LATENCY];
  tag_t                   head;

  logic startAccept, lastIssue, lastWrite;

  logic signed [EXT_BITS-1:0] thrExt, offExt, diff;
  logic [DATA_BITS-1:0]       tEff, resultValue;
  logic                       isHigh;

  assign memBus.oThresholdCol = memBus.oImageCol;
  assign memBus.oThresholdRow = memBus.oImageRow;
  assign head = pipe[MEM_LATENCY-1];

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState   = state;
    startAccept = iStart && ((state == IDLE) || (state == DONE));
    lastIssue   = (colCount == '1) && (rowCount == '1);
    lastWrite   = memBus.oResultWren && (memBus.oResultCol == '1) && (memBus.oResultRow == '1);
    oBusy       = (state == RUN) || (state == DRAIN);
    finished    = (state == DONE);
    case (state)
      IDLE:    if (iStart)    nextState = RUN;
      RUN:     if (lastIssue) nextState = DRAIN;
      DRAIN:   if (lastWrite) nextState = DONE;
      DONE:    if (iStart)    nextState = RUN;
      default: nextState = IDLE;
    endcase
  end

  // Start only arms the counters; the first address is registered one edge later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      modeReg          <= MODE_BINARY;
      offsetReg        <= '0;
      highReg          <= '0;
      lowReg           <= '0;
      colCount         <= '0;
      rowCount         <= '0;
      issueValid       <= 1'b0;
      memBus.oImageCol <= '0;
      memBus.oImageRow <= '0;
    end else begin
      issueValid <= 1'b0;
      if (startAccept) begin
        modeReg   <= mode_t'(iMode);
        offsetReg <= iOffset;
        highReg   <= iHigh;
        lowReg    <= iLow;
        colCount  <= '0;
        rowCount  <= '0;
      end else if (state == RUN) begin
        memBus.oImageCol <= colCount;
        memBus.oImageRow <= rowCount;
        issueValid       <= 1'b1;
        colCount         <= colCount + 1'b1;
        if (colCount == '1) rowCount <= rowCount + 1'b1;
      end
    end
  end

  // Tags travel alongside the memory read so the write address lines up with its data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: issueValid, col: memBus.oImageCol, row: memBus.oImageRow};
      for (int unsigned i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    thrExt = EXT_BITS'(memBus.iThresholdData);
    offExt = EXT_BITS'(offsetReg);
    diff   = thrExt - offExt;
    if (diff[EXT_BITS-1])                     tEff = '0;
    else if (|diff[EXT_BITS-2:DATA_BITS])     tEff = '1;
    else                                      tEff = diff[DATA_BITS-1:0];
    isHigh = memBus.iImageData > tEff;
    resultValue = '0;
    case (modeReg)
      MODE_BINARY:   resultValue = isHigh ? highReg : lowReg;
      MODE_INVERSE:  resultValue = isHigh ? lowReg : highReg;
      MODE_TRUNCATE: resultValue = isHigh ? tEff : memBus.iImageData;
      MODE_TOZERO:   resultValue = isHigh ? memBus.iImageData : '0;
      default:       resultValue = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      memBus.oResultWren <= 1'b0;
      memBus.oResultData <= '0;
      memBus.oResultCol  <= '0;
      memBus.oResultRow  <= '0;
      oCountHigh         <= '0;
    end else begin
      memBus.oResultWren <= head.valid;
      if (head.valid) begin
        memBus.oResultData <= resultValue;
        memBus.oResultCol  <= head.col;
        memBus.oResultRow  <= head.row;
        if (isHigh) oCountHigh <= oCountHigh + 1'b1;
      end
      if (startAccept) oCountHigh <= '0;
    end
  end

endmodule

// File: tb/tb_adaptive_threshold_engine.sv
// Directed bench for adaptive_threshold_engine on a 4x4 image at memory latencies 1 and 3,
// with a scoreboard of expected writes (address, data, arrival cycle).
module tb_adaptive_threshold_engine;
  localparam int WB = 2;
  localparam int HB = 2;
  localparam int DB = 8;
  localparam int OB = 8;
  localparam int N  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic              start1 = 1'b0, start3 = 1'b0;
  logic [1:0]        mode = '0;
  logic signed [7:0] offset = '0;
  logic [7:0]        high = '0, low = '0;
  logic              busy1, fin1, busy3, fin3;
  logic [4:0]        count1, count3;

  adaptive_threshold_engine_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DATA_BITS(DB)) bus1 ();
  adaptive_threshold_engine_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DATA_BITS(DB)) bus3 ();

  adaptive_threshold_engine #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DATA_BITS(DB), .OFFSET_BITS(OB), .MEM_LATENCY(1)
  ) dut1 (
    .clock(clock), .reset(reset), .iStart(start1), .iMode(mode), .iOffset(offset),
    .iHigh(high), .iLow(low), .memBus(bus1), .oBusy(busy1), .finished(fin1),
    .oCountHigh(count1)
  );

  adaptive_threshold_engine #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .DATA_BITS(DB), .OFFSET_BITS(OB), .MEM_LATENCY(3)
  ) dut3 (
    .clock(clock), .reset(reset), .iStart(start3), .iMode(mode), .iOffset(offset),
    .iHigh(high), .iLow(low), .memBus(bus3), .oBusy(busy3), .finished(fin3),
    .oCountHigh(count3)
  );

  logic [7:0] imgMem [N];
  logic [7:0] thrMem [N];
  logic [7:0] img3 [2];
  logic [7:0] thr3 [2];

  always @(posedge clock) begin
    bus1.iImageData     <= imgMem[{bus1.oImageRow, bus1.oImageCol}];
    bus1.iThresholdData <= thrMem[{bus1.oThresholdRow, bus1.oThresholdCol}];
    img3[0]             <= imgMem[{bus3.oImageRow, bus3.oImageCol}];
    thr3[0]             <= thrMem[{bus3.oThresholdRow, bus3.oThresholdCol}];
    img3[1]             <= img3[0];
    thr3[1]             <= thr3[0];
    bus3.iImageData     <= img3[1];
    bus3.iThresholdData <= thr3[1];
  end

  typedef struct {
    int col;
    int row;
    int data;
    int cyc;
  } exp_t;

  exp_t q1[$], q3[$];
  exp_t e1, e3;
  int checks = 0, failures = 0, cyc = 0, wr1 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus1.oResultWren === 1'b1) begin
      wr1++;
      check("wr1_expected", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("wr1_addr", {bus1.oResultRow, bus1.oResultCol}, e1.row * 4 + e1.col);
        check("wr1_data", bus1.oResultData, e1.data);
        check("wr1_cycle", cyc, e1.cyc);
      end
    end
    if (bus3.oResultWren === 1'b1) begin
      check("wr3_expected", q3.size() != 0, 1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        check("wr3_addr", {bus3.oResultRow, bus3.oResultCol}, e3.row * 4 + e3.col);
        check("wr3_data", bus3.oResultData, e3.data);
        check("wr3_cycle", cyc, e3.cyc);
      end
    end
  end

  task automatic checkReset1();
    check("rst_wren", bus1.oResultWren, 0);
    check("rst_data", bus1.oResultData, 0);
    check("rst_raddr", {bus1.oResultRow, bus1.oResultCol}, 0);
    check("rst_iaddr", {bus1.oImageRow, bus1.oImageCol}, 0);
    check("rst_taddr", {bus1.oThresholdRow, bus1.oThresholdCol}, 0);
    check("rst_busy", busy1, 0);
    check("rst_fin", fin1, 0);
    check("rst_count", count1, 0);
  endtask

  task automatic runFrame(input int dut, input int m, input int off, input int hi,
                          input int lo, input bit poke, input int abortAt);
    int lat, expCount, t, r, startCyc, lastData;
    bit isHi, done;
    exp_t e;
    lat = (dut == 3) ? 3 : 1;
    expCount = 0;
    lastData = 0;
    done = 0;
    @(negedge clock);
    wr1 = 0;
    mode = m[1:0];
    offset = off[7:0];
    high = hi[7:0];
    low = lo[7:0];
    if (dut == 3) start3 = 1'b1; else start1 = 1'b1;
    startCyc = cyc + 1;
    for (int n = 0; n < N; n++) begin
      t = int'(thrMem[n]) - off;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      isHi = int'(imgMem[n]) > t;
      case (m)
        0:       r = isHi ? hi : lo;
        1:       r = isHi ? lo : hi;
        2:       r = isHi ? t : int'(imgMem[n]);
        default: r = isHi ? int'(imgMem[n]) : 0;
      endcase
      if (isHi) expCount++;
      lastData = r;
      e = '{n % 4, n / 4, r, startCyc + 2 + n + lat};
      if (dut == 3) q3.push_back(e); else q1.push_back(e);
    end
    @(negedge clock);
    start1 = 1'b0;
    start3 = 1'b0;
    check("fin_drop", (dut == 3) ? fin3 : fin1, 0);
    check("busy_rise", (dut == 3) ? busy3 : busy1, 1);
    // Scramble live config: the engine must use the values latched at start.
    mode = ~m[1:0];
    offset = 8'($urandom);
    high = ~high;
    low = ~low;
    for (int i = 0; i < 200; i++) begin
      if (((dut == 3) ? fin3 : fin1) === 1'b1) begin
        done = 1;
        break;
      end
      if (abortAt > 0 && wr1 >= abortAt) break;
      if (dut == 3) start3 = poke && (i == 5); else start1 = poke && (i == 5);
      @(negedge clock);
      #1;
    end
    start1 = 1'b0;
    start3 = 1'b0;
    if (abortAt > 0) begin
      reset = 1'b0;
      q1.delete();
      @(negedge clock);
      checkReset1();
      @(negedge clock);
      reset = 1'b1;
      repeat (10) @(negedge clock);
      check("abort_idle_busy", busy1, 0);
      check("abort_idle_fin", fin1, 0);
      return;
    end
    check("finish_seen", done, 1);
    check("finish_cycle", cyc - startCyc, N + lat + 2);
    check("busy_fall", (dut == 3) ? busy3 : busy1, 0);
    check("count_high", (dut == 3) ? count3 : count1, expCount);
    check("sb_drained", (dut == 3) ? q3.size() : q1.size(), 0);
    repeat (3) @(negedge clock);
    check("fin_hold", (dut == 3) ? fin3 : fin1, 1);
    check("count_hold", (dut == 3) ? count3 : count1, expCount);
    check("data_hold", (dut == 3) ? bus3.oResultData : bus1.oResultData, lastData);
  endtask

  initial begin
    for (int n = 0; n < N; n++) begin
      imgMem[n] = 8'(16 * n);
      thrMem[n] = 8'd128;
    end
    repeat (3) @(negedge clock);
    checkReset1();
    check("rst_count3", count3, 0);
    check("rst_fin3", fin3, 0);
    reset = 1'b1;
    @(negedge clock);

    runFrame(1, 0, 0, 255, 0, 0, 0);
    runFrame(1, 0, 16, 255, 0, 0, 0);
    runFrame(1, 0, -16, 255, 0, 0, 0);
    runFrame(1, 1, 0, 255, 0, 0, 0);
    runFrame(1, 0, 0, 255, 0, 1, 0);
    runFrame(1, 0, 0, 255, 0, 0, 5);
    runFrame(1, 0, 0, 255, 0, 0, 0);
    runFrame(3, 0, 0, 255, 0, 0, 0);
    runFrame(3, 1, 16, 200, 10, 0, 0);

    for (int n = 0; n < N; n++) thrMem[n] = 8'd5;
    runFrame(1, 0, 20, 255, 0, 0, 0);
    for (int n = 0; n < N; n++) thrMem[n] = 8'd250;
    runFrame(1, 0, -20, 255, 0, 0, 0);

    for (int n = 0; n < N; n++) begin
      imgMem[n] = (n % 2 == 0) ? 8'd200 : 8'd50;
      thrMem[n] = 8'd100;
    end
    runFrame(1, 2, 0, 255, 0, 0, 0);
    runFrame(1, 3, 0, 255, 0, 0, 0);
    runFrame(3, 2, -30, 255, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end
endmodule
